// File: rtl/data_stack.sv
// data_stack: hardware LIFO for accumulator values, driven by the decoder's
// push/pop strobes (PUSH, POP, SADD, SMLT).
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous reset, active-high; clears pointer and error flags
//   en         instruction-valid strobe; push/pop are ignored while low
//   push       push request (decoder data_sp_push)
//   pop        pop request (decoder data_sp_pop)
//   push_data  value to push, stored bit-exact
//   clr_err    clears the sticky overflow/underflow flags
//   top_data   current top-of-stack entry, 0 when empty (registered state only)
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
module data_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             top_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_PUSH,
    ACT_PUSH_FULL,
    ACT_POP,
    ACT_POP_EMPTY,
    ACT_REPLACE,
    ACT_REPLACE_EMPTY
  } action_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             req_push, req_pop;
  logic             is_empty, is_full;
  action_e          act;

  logic             we;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             set_ovf, set_udf;

  assign req_push = en & push;
  assign req_pop  = en & pop;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));

  // sp-1 only addresses the array when the stack is non-empty, so the
  // wrapped value at sp==0 is never observed.
  assign top_idx  = AW'(sp_q - CW'(1));

  // Decode the request against the current occupancy.
  always_comb begin
    act = ACT_HOLD;
    if (req_push && !req_pop) begin
      act = is_full ? ACT_PUSH_FULL : ACT_PUSH;
    end else if (req_pop && !req_push) begin
      act = is_empty ? ACT_POP_EMPTY : ACT_POP;
    end else if (req_push && req_pop) begin
      act = is_empty ? ACT_REPLACE_EMPTY : ACT_REPLACE;
    end
  end

  // Next-state for pointer, write port and error events.
  always_comb begin
    sp_d    = sp_q;
    we      = 1'b0;
    wr_idx  = sp_q[AW-1:0];
    set_ovf = 1'b0;
    set_udf = 1'b0;
    case (act)
      ACT_PUSH: begin
        we     = 1'b1;
        wr_idx = sp_q[AW-1:0];
        sp_d   = sp_q + CW'(1);
      end
      ACT_PUSH_FULL: begin
        set_ovf = 1'b1;
      end
      ACT_POP: begin
        // Entry contents stay in place; they just fall out of view.
        sp_d = sp_q - CW'(1);
      end
      ACT_POP_EMPTY: begin
        set_udf = 1'b1;
      end
      ACT_REPLACE: begin
        we     = 1'b1;
        wr_idx = top_idx;
      end
      ACT_REPLACE_EMPTY: begin
        // Pop side underflows, push side still lands in entry 0.
        we      = 1'b1;
        wr_idx  = '0;
        sp_d    = CW'(1);
        set_udf = 1'b1;
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    ovf_d = set_ovf | (ovf_q & ~clr_err);
    udf_d = set_udf | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Storage has no reset; contents are only visible below sp.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  assign top_data  = is_empty ? '0 : mem_q[top_idx];
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
